// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined EX-stage ALU.
// Covers op encodings, flag bit positions, FSM states and the multicycle-op classifier.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_OP_ADD   = 4'd0,
        ALU_OP_SUB   = 4'd1,
        ALU_OP_AND   = 4'd2,
        ALU_OP_OR    = 4'd3,
        ALU_OP_SLT   = 4'd4,
        ALU_OP_SLTU  = 4'd5,
        ALU_OP_PASSB = 4'd6,
        ALU_OP_SLL   = 4'd7,
        ALU_OP_SRL   = 4'd8,
        ALU_OP_SRA   = 4'd9,
        ALU_OP_MULT  = 4'd10,
        ALU_OP_MULTU = 4'd11,
        ALU_OP_DIV   = 4'd12,
        ALU_OP_DIVU  = 4'd13
    } alu_op_e;

    localparam int unsigned FLAG_BIT_ZERO     = 0;
    localparam int unsigned FLAG_BIT_OVERFLOW = 1;
    localparam int unsigned FLAG_BIT_DIVZERO  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    function automatic logic is_multicycle(input logic [3:0] op);
        return op inside {ALU_OP_MULT, ALU_OP_MULTU, ALU_OP_DIV, ALU_OP_DIVU};
    endfunction

endpackage

// File: rtl/pipelined_alu_muldiv_iter.sv
// Iterative engine: shift-add multiply or restoring divide, one bit per cycle.
// Operates on magnitudes; the sign fix-up is applied to the final step's combinational output.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             is_signed,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic               busy;
    logic [SHW-1:0]     cnt;
    logic               mode_q;
    logic               neg_q;
    logic               rneg_q;
    logic [WIDTH:0]     acc;
    logic [WIDTH-1:0]   qr;
    logic [WIDTH-1:0]   bm;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     add;
    logic [WIDTH:0]     sh;
    logic [WIDTH+1:0]   diff;
    logic [WIDTH:0]     acc_n;
    logic [WIDTH-1:0]   qr_n;
    logic [2*WIDTH-1:0] prod;

    assign a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

    // The last step is never registered; done/hi/lo present it combinationally.
    assign done = busy && (cnt == SHW'(WIDTH-1));

    always_comb begin
        add  = {1'b0, acc[WIDTH-1:0]} + (qr[0] ? {1'b0, bm} : '0);
        sh   = {acc[WIDTH-1:0], qr[WIDTH-1]};
        diff = {1'b0, sh} - {2'b00, bm};
        if (!mode_q) begin
            acc_n = {1'b0, add[WIDTH:1]};
            qr_n  = {add[0], qr[WIDTH-1:1]};
        end else if (!diff[WIDTH+1]) begin
            acc_n = diff[WIDTH:0];
            qr_n  = {qr[WIDTH-2:0], 1'b1};
        end else begin
            acc_n = sh;
            qr_n  = {qr[WIDTH-2:0], 1'b0};
        end

        prod = {acc_n[WIDTH-1:0], qr_n};
        if (neg_q) begin
            prod = -prod;
        end

        if (!mode_q) begin
            hi = prod[2*WIDTH-1:WIDTH];
            lo = prod[WIDTH-1:0];
        end else begin
            lo = neg_q  ? -qr_n : qr_n;
            hi = rneg_q ? -acc_n[WIDTH-1:0] : acc_n[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy   <= 1'b0;
            cnt    <= '0;
            mode_q <= 1'b0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            acc    <= '0;
            qr     <= '0;
            bm     <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            mode_q <= mode;
            neg_q  <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            rneg_q <= is_signed && a[WIDTH-1];
            acc    <= '0;
            qr     <= a_mag;
            bm     <= b_mag;
        end else if (busy) begin
            acc <= acc_n;
            qr  <= qr_n;
            cnt <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pipelined_alu.sv
// Registered valid/ready EX-stage ALU with an internal sticky flag register.
// Single-cycle ops finish on the accept edge; mul/div run WIDTH cycles in muldiv_iter.
module pipelined_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH),
    parameter int unsigned FLAGW = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    input  logic             flag_clr,
    output logic [FLAGW-1:0] flags
);

    alu_state_e state, state_n;
    alu_op_e    opc;

    logic             accept;
    logic             op_md;
    logic             op_div;
    logic             op_divz;
    logic             go_busy;
    logic             md_start;
    logic             md_done;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;

    logic [WIDTH-1:0]        y_eff;
    logic [WIDTH:0]          sum;
    logic                    add_ovf;
    logic [SHW-1:0]          shamt;
    logic signed [WIDTH-1:0] sra_v;
    logic [WIDTH-1:0]        sc_res;
    logic                    sc_ovf;

    logic             wr;
    logic             set_ovf;
    logic             set_dz;
    logic [WIDTH-1:0] res_n;
    logic [WIDTH-1:0] hi_n;
    logic [WIDTH-1:0] lo_n;
    logic [FLAGW-1:0] flags_n;

    assign opc      = alu_op_e'(op);
    assign op_md    = is_multicycle(op);
    assign op_div   = (opc == ALU_OP_DIV) || (opc == ALU_OP_DIVU);
    assign op_divz  = op_div && (y == '0);
    assign go_busy  = op_md && !op_divz;
    assign md_start = accept && go_busy;
    assign out_valid = (state == ST_DONE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Accepting in DONE retires the held result on the same edge, so no bubble.
    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        case (state)
            ST_IDLE: in_ready = 1'b1;
            ST_BUSY: if (md_done) state_n = ST_DONE;
            ST_DONE: begin
                in_ready = out_ready;
                if (out_ready) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
        accept = in_valid && in_ready;
        if (accept) begin
            state_n = go_busy ? ST_BUSY : ST_DONE;
        end
    end

    muldiv_iter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_muldiv (
        .clk       (clk),
        .rstn      (rstn),
        .start     (md_start),
        .is_signed ((opc == ALU_OP_MULT) || (opc == ALU_OP_DIV)),
        .mode      (op_div),
        .a         (x),
        .b         (y),
        .done      (md_done),
        .hi        (md_hi),
        .lo        (md_lo)
    );

    assign shamt = x[SHW-1:0];
    assign sra_v = $signed(y) >>> shamt;

    always_comb begin
        y_eff   = (opc == ALU_OP_SUB) ? ~y : y;
        sum     = {1'b0, x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, (opc == ALU_OP_SUB)};
        add_ovf = sum[WIDTH] ^ sum[WIDTH-1] ^ x[WIDTH-1] ^ y_eff[WIDTH-1];
        sc_res  = '0;
        sc_ovf  = 1'b0;
        case (opc)
            ALU_OP_ADD, ALU_OP_SUB: begin
                sc_res = sum[WIDTH-1:0];
                sc_ovf = add_ovf;
            end
            ALU_OP_AND:   sc_res = x & y;
            ALU_OP_OR:    sc_res = x | y;
            ALU_OP_SLT:   sc_res = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
            ALU_OP_SLTU:  sc_res = {{(WIDTH-1){1'b0}}, (x < y)};
            ALU_OP_PASSB: sc_res = y;
            ALU_OP_SLL:   sc_res = y << shamt;
            ALU_OP_SRL:   sc_res = y >> shamt;
            ALU_OP_SRA:   sc_res = sra_v;
            default:      sc_res = '0;
        endcase
    end

    // A flag update overrides flag_clr only for the bits it actually writes.
    always_comb begin
        wr      = 1'b0;
        set_ovf = 1'b0;
        set_dz  = 1'b0;
        res_n   = result;
        hi_n    = hi;
        lo_n    = lo;
        if (accept) begin
            if (op_divz) begin
                wr     = 1'b1;
                set_dz = 1'b1;
                hi_n   = x;
                lo_n   = '1;
                res_n  = '1;
            end else if (!op_md) begin
                wr      = 1'b1;
                set_ovf = sc_ovf;
                res_n   = sc_res;
            end
        end else if ((state == ST_BUSY) && md_done) begin
            wr    = 1'b1;
            hi_n  = md_hi;
            lo_n  = md_lo;
            res_n = md_lo;
        end

        flags_n = flag_clr ? '0 : flags;
        if (wr) begin
            flags_n[FLAG_BIT_ZERO] = (res_n == '0);
            if (set_ovf) flags_n[FLAG_BIT_OVERFLOW] = 1'b1;
            if (set_dz)  flags_n[FLAG_BIT_DIVZERO]  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            result <= '0;
            hi     <= '0;
            lo     <= '0;
            flags  <= '0;
        end else begin
            result <= res_n;
            hi     <= hi_n;
            lo     <= lo_n;
            flags  <= flags_n;
        end
    end

endmodule
